// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF)
// and the data-memory stage (DM). Data requests win unless the optional
// starvation guard (enabled by defining ARB_STARVE_GUARD_EN) forces a fetch
// grant after STARVE_LIMIT consecutive DM grants made while IF was waiting.
// Each access runs IDLE -> IF_ACC/DM_ACC -> RESP -> IDLE.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // fetch port
    input  logic        if_read_i,
    input  logic [31:0] if_address_i,
    output logic [31:0] if_readdata_o,
    output logic        if_busywait_o,
    // data port
    input  logic        dm_read_i,
    input  logic        dm_write_i,
    input  logic [2:0]  dm_funct3_i,
    input  logic [31:0] dm_address_i,
    input  logic [31:0] dm_writedata_i,
    output logic [31:0] dm_readdata_o,
    output logic        dm_busywait_o,
    // unified memory port
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_writedata_o,
    output logic [2:0]  mem_funct3_o,
    input  logic [31:0] mem_readdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, RESP} state_e;
    typedef enum logic {PORT_IF, PORT_DM} port_e;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    state_e      state_q, state_d;
    port_e       served_q, served_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_writedata_q, mem_writedata_d;
    logic [2:0]  mem_funct3_q, mem_funct3_d;
    logic [31:0] if_readdata_q, if_readdata_d;
    logic [31:0] dm_readdata_q, dm_readdata_d;

    logic dm_req;
    logic force_if;
    logic grant_if;
    logic grant_dm;
    logic acc_done;

    assign dm_req   = dm_read_i | dm_write_i;
    assign acc_done = ((state_q == IF_ACC) || (state_q == DM_ACC)) && mem_ack_i;

`ifdef ARB_STARVE_GUARD_EN
    localparam int               CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // Fetch is forced only when both ports contend and DM has had its quota.
    assign force_if = if_read_i && dm_req && (starve_cnt_q == LIMIT_CNT);

    // Count DM grants that left a waiting fetch behind; any fetch grant or an
    // uncontended DM grant restarts the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_if) begin
            starve_cnt_d = '0;
        end else if (grant_dm) begin
            if (!if_read_i) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != LIMIT_CNT) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    logic unused_starve_limit;

    // Strict DM priority: the limit has no effect in this build.
    assign force_if            = 1'b0;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

    // State register.
    // NOTE: sequential blocks use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and grant decision; grants are only made from IDLE.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dm_req && !force_if) begin
                    state_d  = DM_ACC;
                    grant_dm = 1'b1;
                end else if (if_read_i) begin
                    state_d  = IF_ACC;
                    grant_if = 1'b1;
                end
            end
            IF_ACC, DM_ACC: begin
                if (mem_ack_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
    end

    // Busywait outputs: released only in the RESP cycle of the served port,
    // and held low while reset is asserted.
    always_comb begin
        if_busywait_o = 1'b0;
        dm_busywait_o = 1'b0;
        if (rst_ni) begin
            if_busywait_o = if_read_i && !((state_q == RESP) && (served_q == PORT_IF));
            dm_busywait_o = dm_req && !((state_q == RESP) && (served_q == PORT_DM));
        end
    end

    // Memory-port and read-data next values: launch on grant, hold during the
    // access, capture return data and drop strobes on the ack edge.
    always_comb begin
        served_d        = served_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        mem_funct3_d    = mem_funct3_q;
        if_readdata_d   = if_readdata_q;
        dm_readdata_d   = dm_readdata_q;
        if (grant_dm) begin
            // A simultaneous read and write is issued as a write.
            served_d        = PORT_DM;
            mem_address_d   = dm_address_i;
            mem_writedata_d = dm_writedata_i;
            mem_funct3_d    = dm_funct3_i;
            mem_write_d     = dm_write_i;
            mem_read_d      = !dm_write_i;
        end else if (grant_if) begin
            served_d      = PORT_IF;
            mem_address_d = if_address_i;
            mem_funct3_d  = FUNCT3_WORD;
            mem_read_d    = 1'b1;
            mem_write_d   = 1'b0;
        end else if (acc_done) begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            if (served_q == PORT_IF) begin
                if_readdata_d = mem_readdata_i;
            end else if (mem_read_q) begin
                dm_readdata_d = mem_readdata_i;
            end
        end
    end

    // Memory-port and read-data registers; reset drops strobes immediately,
    // abandoning any access in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            served_q        <= PORT_IF;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            mem_funct3_q    <= '0;
            if_readdata_q   <= '0;
            dm_readdata_q   <= '0;
        end else begin
            served_q        <= served_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            mem_funct3_q    <= mem_funct3_d;
            if_readdata_q   <= if_readdata_d;
            dm_readdata_q   <= dm_readdata_d;
        end
    end

    assign mem_read_o      = mem_read_q;
    assign mem_write_o     = mem_write_q;
    assign mem_address_o   = mem_address_q;
    assign mem_writedata_o = mem_writedata_q;
    assign mem_funct3_o    = mem_funct3_q;
    assign if_readdata_o   = if_readdata_q;
    assign dm_readdata_o   = dm_readdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized phase.
// Expected responses are queued when a request is issued and popped by an
// independent monitor when the DUT releases busywait.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int          LIMIT  = 2;
    localparam logic [31:0] IF_TOP = 32'h100;  // fetch addresses lie below, data at/above
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_read_i;
    logic [31:0] if_address_i;
    logic [31:0] if_readdata_o;
    logic        if_busywait_o;
    logic        dm_read_i;
    logic        dm_write_i;
    logic [2:0]  dm_funct3_i;
    logic [31:0] dm_address_i;
    logic [31:0] dm_writedata_i;
    logic [31:0] dm_readdata_o;
    logic        dm_busywait_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_writedata_o;
    logic [2:0]  mem_funct3_o;
    logic [31:0] mem_readdata_i;
    logic        mem_ack_i;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .if_read_i(if_read_i), .if_address_i(if_address_i),
        .if_readdata_o(if_readdata_o), .if_busywait_o(if_busywait_o),
        .dm_read_i(dm_read_i), .dm_write_i(dm_write_i), .dm_funct3_i(dm_funct3_i),
        .dm_address_i(dm_address_i), .dm_writedata_i(dm_writedata_i),
        .dm_readdata_o(dm_readdata_o), .dm_busywait_o(dm_busywait_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_address_o(mem_address_o), .mem_writedata_o(mem_writedata_o),
        .mem_funct3_o(mem_funct3_o), .mem_readdata_i(mem_readdata_i),
        .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
    } bus_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mem     [bit [31:0]];  // memory seen by the DUT
    logic [31:0] ref_mem [bit [31:0]];  // reference contents
    logic [31:0] if_exp_q[$];
    logic [31:0] dm_exp_q[$];
    bus_t        dm_bus_q[$];
    int          grant_log[$];          // 0 = fetch access, 1 = data access
    logic [31:0] model_last_load;       // reference DM_READDATA
    int          n_access      = 0;
    int          strobe_cycles = 0;
    int          lat_cfg       = 1;     // 0 selects a random ack latency
    bit          spur_en       = 1'b0;  // stray acks while no strobe is up
    int          mm_cnt        = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [31:0] fill(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : fill(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    function automatic logic [31:0] rand_if_addr();
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    function automatic logic [31:0] rand_dm_addr();
        return IF_TOP + (32'($urandom_range(0, 63)) << 2);
    endfunction

    function automatic int grant_at(input int i);
        if (i < grant_log.size()) return grant_log[i];
        return -1;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    // Called when the memory model sees a new access start.
    task automatic log_access();
        bus_t e;
        n_access++;
        if (mem_address_o < IF_TOP) begin
            grant_log.push_back(0);
            check("if_bus_ctrl", 32'({mem_write_o, mem_read_o, mem_funct3_o}), 32'({1'b0, 1'b1, 3'b010}));
        end else begin
            grant_log.push_back(1);
            if (dm_bus_q.size() == 0) begin
                fail_now("dm_bus_unexpected");
            end else begin
                e = dm_bus_q.pop_front();
                check("dm_bus_addr", mem_address_o, e.addr);
                check("dm_bus_ctrl", 32'({mem_write_o, mem_read_o, mem_funct3_o}), 32'({e.wr, ~e.wr, e.f3}));
                if (e.wr) check("dm_bus_wdata", mem_writedata_o, e.wdata);
            end
        end
    endtask

    // Memory model: ack after lat_cfg (or random 1..3) access cycles.
    initial begin : mem_model
        mem_ack_i      = 1'b0;
        mem_readdata_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_ack_i      = 1'b0;
            mem_readdata_i = $urandom;
            if (!(mem_read_o || mem_write_o)) begin
                mm_cnt = 0;
                if (spur_en && $urandom_range(0, 3) == 0) mem_ack_i = 1'b1;
            end else begin
                if (mm_cnt == 0) begin
                    mm_cnt = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 3));
                    log_access();
                end
                mm_cnt--;
                if (mm_cnt == 0) begin
                    mem_ack_i = 1'b1;
                    if (mem_write_o) mem[mem_address_o] = mem_writedata_o;
                    else mem_readdata_i = mem_rd(mem_address_o);
                end
            end
        end
    end

    // Strobe-cycle counter.
    initial begin : strobe_mon
        forever begin
            @(negedge clk_i);
            if (mem_read_o) strobe_cycles++;
        end
    end

    // Completion monitor: a held request with busywait low is a completion.
    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (rst_ni && if_read_i && !if_busywait_o) begin
                if (if_exp_q.size() == 0) fail_now("if_resp_unexpected");
                else check("if_readdata", if_readdata_o, if_exp_q.pop_front());
            end
            if (rst_ni && (dm_read_i || dm_write_i) && !dm_busywait_o) begin
                if (dm_exp_q.size() == 0) fail_now("dm_resp_unexpected");
                else check("dm_readdata", dm_readdata_o, dm_exp_q.pop_front());
            end
        end
    end

    task automatic if_idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
            if_read_i = 1'b0;
        end
    endtask

    task automatic dm_idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
            dm_read_i  = 1'b0;
            dm_write_i = 1'b0;
        end
    endtask

    task automatic if_req(input logic [31:0] a, output int lat);
        @(posedge clk_i);
        #1;
        if_read_i    = 1'b1;
        if_address_i = a;
        if_exp_q.push_back(ref_rd(a));
        lat = 0;
        forever begin
            @(negedge clk_i);
            if (!if_busywait_o) break;
            lat++;
            if (lat > 300) begin
                fail_now("if_timeout");
                void'(if_exp_q.pop_back());
                break;
            end
        end
    endtask

    task automatic dm_req(input bit wr, input bit both, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f3, output int lat);
        @(posedge clk_i);
        #1;
        dm_write_i     = wr;
        dm_read_i      = !wr || both;
        dm_address_i   = a;
        dm_writedata_i = d;
        dm_funct3_i    = f3;
        dm_bus_q.push_back('{wr, a, f3, d});
        if (wr) begin
            ref_mem[a] = d;
        end else begin
            model_last_load = ref_rd(a);
        end
        dm_exp_q.push_back(model_last_load);
        lat = 0;
        forever begin
            @(negedge clk_i);
            if (!dm_busywait_o) break;
            lat++;
            if (lat > 300) begin
                fail_now("dm_timeout");
                void'(dm_exp_q.pop_back());
                break;
            end
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int lat_if, lat_dm, g0, a0, s0;
    int pend_if, pend_dm, streak, exp_port;
    bit rnd_wr, rnd_both;

    initial begin : main
        rst_ni = 1'b0;
        if_read_i = 1'b1;  dm_read_i = 1'b0;  dm_write_i = 1'b1;
        if_address_i = 32'h40;  dm_address_i = 32'h100;
        dm_writedata_i = 32'hFFFF_FFFF;  dm_funct3_i = 3'b111;
        model_last_load = '0;
        preload(32'h40, 32'h00500093);
        preload(32'h180, 32'h12345678);

        // Reset state, with requests asserted to show busywait is forced low.
        repeat (2) @(posedge clk_i);
        #3;
        check("rst_if_busywait", 32'(if_busywait_o), 32'd0);
        check("rst_dm_busywait", 32'(dm_busywait_o), 32'd0);
        check("rst_strobes", 32'({mem_read_o, mem_write_o}), 32'd0);
        check("rst_mem_address", mem_address_o, 32'd0);
        check("rst_mem_wdata", mem_writedata_o, 32'd0);
        check("rst_mem_funct3", 32'(mem_funct3_o), 32'd0);
        check("rst_if_readdata", if_readdata_o, 32'd0);
        check("rst_dm_readdata", dm_readdata_o, 32'd0);
        if_read_i = 1'b0;  dm_write_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Lone fetch, ack in the first access cycle.
        s0 = strobe_cycles;
        if_req(32'h40, lat_if);
        check("fetch_latency", 32'(lat_if), 32'd2);
        check("fetch_data", if_readdata_o, 32'h00500093);
        check("fetch_strobe_cycles", 32'(strobe_cycles - s0), 32'd1);
        if_idle(1);

        // Store then slow load to 0x100.
        dm_req(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 3'b010, lat_dm);
        check("store_latency", 32'(lat_dm), 32'd2);
        check("store_landed", mem_rd(32'h100), 32'hDEADBEEF);
        dm_idle(1);
        lat_cfg = 3;
        dm_req(1'b0, 1'b0, 32'h100, 32'h0BAD_F00D, 3'b010, lat_dm);
        check("load_busywait_cycles", 32'(lat_dm), 32'd4);
        check("load_data", dm_readdata_o, 32'hDEADBEEF);
        dm_idle(1);
        lat_cfg = 1;

        // Simultaneous requests: data first, fetch from the next IDLE.
        g0 = grant_log.size();
        fork
            begin if_req(32'h44, lat_if); if_idle(1); end
            begin dm_req(1'b0, 1'b0, 32'h200, 32'h1357_9BDF, 3'b010, lat_dm); dm_idle(1); end
        join
        check("simul_first_dm", 32'(grant_at(g0)), 32'd1);
        check("simul_second_if", 32'(grant_at(g0 + 1)), 32'd0);
        check("simul_dm_latency", 32'(lat_dm), 32'd2);
        check("simul_if_latency", 32'(lat_if), 32'd5);

        // Both ports held busy: 4 data reads and 2 fetches.
        g0 = grant_log.size();
        fork
            begin repeat (2) if_req(rand_if_addr(), lat_if); if_idle(1); end
            begin repeat (4) dm_req(1'b0, 1'b0, rand_dm_addr(), $urandom, 3'b010, lat_dm); dm_idle(1); end
        join
        pend_if = 2;  pend_dm = 4;  streak = 0;
        for (int i = 0; i < 6; i++) begin
            if (pend_dm > 0 && !(GUARD && pend_if > 0 && streak == LIMIT)) begin
                exp_port = 1;
                streak   = (pend_if > 0) ? streak + 1 : 0;
                pend_dm--;
            end else begin
                exp_port = 0;
                streak   = 0;
                pend_if--;
            end
            check($sformatf("contend_grant_%0d", i), 32'(grant_at(g0 + i)), 32'(exp_port));
        end

        // Reset while a data read waits for its ack.
        lat_cfg = 6;
        @(posedge clk_i);
        #1;
        dm_read_i = 1'b1;  dm_write_i = 1'b0;
        dm_address_i = 32'h1C0;  dm_funct3_i = 3'b010;  dm_writedata_i = 32'hA5A5_5A5A;
        dm_bus_q.push_back('{1'b0, 32'h1C0, 3'b010, 32'hA5A5_5A5A});
        @(posedge clk_i);
        @(negedge clk_i);
        check("midrst_strobe_before", 32'(mem_read_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_strobes", 32'({mem_read_o, mem_write_o}), 32'd0);
        check("midrst_mem_address", mem_address_o, 32'd0);
        check("midrst_mem_wdata", mem_writedata_o, 32'd0);
        check("midrst_if_readdata", if_readdata_o, 32'd0);
        check("midrst_dm_readdata", dm_readdata_o, 32'd0);
        check("midrst_dm_busywait", 32'(dm_busywait_o), 32'd0);
        dm_read_i = 1'b0;
        model_last_load = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni  = 1'b1;
        lat_cfg = 1;
        if_req(rand_if_addr(), lat_if);
        check("postrst_fetch_latency", 32'(lat_if), 32'd2);
        if_idle(1);

        // Data read withdrawn during its access still completes once.
        lat_cfg = 3;
        a0 = n_access;
        @(posedge clk_i);
        #1;
        dm_read_i = 1'b1;  dm_address_i = 32'h180;  dm_funct3_i = 3'b010;
        dm_bus_q.push_back('{1'b0, 32'h180, 3'b010, dm_writedata_i});
        @(posedge clk_i);
        #1;
        dm_read_i = 1'b0;
        repeat (6) @(posedge clk_i);
        @(negedge clk_i);
        check("drop_readdata", dm_readdata_o, 32'h12345678);
        check("drop_single_access", 32'(n_access - a0), 32'd1);
        model_last_load = 32'h12345678;

        // Randomized traffic with random latency and stray acks.
        lat_cfg = 0;
        spur_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if_idle($urandom_range(0, 2));
                    if_req(rand_if_addr(), lat_if);
                end
                if_idle(1);
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    dm_idle($urandom_range(0, 3));
                    rnd_wr   = $urandom_range(0, 1) == 1;
                    rnd_both = rnd_wr && ($urandom_range(0, 3) == 0);
                    dm_req(rnd_wr, rnd_both, rand_dm_addr(), $urandom,
                           3'($urandom_range(0, 7)), lat_dm);
                end
                dm_idle(1);
            end
        join
        spur_en = 1'b0;
        repeat (5) @(negedge clk_i);
        check("if_queue_drained", 32'(if_exp_q.size()), 32'd0);
        check("dm_queue_drained", 32'(dm_exp_q.size()), 32'd0);
        check("bus_queue_drained", 32'(dm_bus_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
